// File: rtl/safety_mute_ramp_pkg.sv
// Shared types and helpers for the safety mute/ramp gain stage and other
// gain stages that need the same unity constant or output saturation.
package safety_mute_ramp_pkg;

  // Gain controller states
  typedef enum logic [1:0] {
    PASS     = 2'd0,
    FADE_OUT = 2'd1,
    MUTED    = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  // Unity gain for an unsigned gain word of the given width (MSB set)
  function automatic logic [31:0] unityGain(input int gainWidth);
    return 32'd1 << (gainWidth - 1);
  endfunction

  // Clamp a wide signed value into the signed range of 'width' bits
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] maxVal;
    logic signed [63:0] minVal;
    maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
    minVal = -(64'sd1 <<< (width - 1));
    if (value > maxVal) begin
      return maxVal;
    end else if (value < minVal) begin
      return minVal;
    end
    return value;
  endfunction

endpackage

// File: rtl/safety_mute_ramp_gain_scaler.sv
// Two-stage signed sample x unsigned gain pipeline with round-half-up and
// saturation. Stage 1 captures sample and gain, stage 2 registers the
// scaled result. The valid bit travels alongside so output valid trails
// input valid by exactly two cycles; the output word holds between samples.
module safety_gain_scaler
  import safety_mute_ramp_pkg::*;
#(
  parameter int data_width = 16,
  parameter int gain_width = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_valid,
  input  logic signed [data_width-1:0] i_sample,
  input  logic        [gain_width-1:0] i_gain,
  output logic signed [data_width-1:0] o_sample,
  output logic                         o_valid
);

  localparam int PW = data_width + gain_width + 1;
  localparam logic signed [PW-1:0] ROUND_BIAS = PW'(64'sd1 <<< (gain_width - 2));

  logic signed [data_width-1:0] r_sample;
  logic        [gain_width-1:0] r_gain;
  logic                         r_valid1;
  logic signed [data_width-1:0] r_out;
  logic                         r_valid2;

  logic signed [PW-1:0]         w_sampleExt;
  logic signed [PW-1:0]         w_gainExt;
  logic signed [PW-1:0]         w_product;
  logic signed [PW-1:0]         w_rounded;
  logic signed [data_width-1:0] w_satOut;

  // Stage 1: capture the sample with the gain that applies to it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= '0;
      r_gain   <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= i_valid;
      if (i_valid) begin
        r_sample <= i_sample;
        r_gain   <= i_gain;
      end
    end
  end

  // Gain is unsigned, so it is zero-extended before the signed multiply;
  // the product always fits since gain never exceeds unity.
  assign w_sampleExt = PW'(r_sample);
  assign w_gainExt   = $signed(PW'(r_gain));
  assign w_product   = w_sampleExt * w_gainExt;
  assign w_rounded   = (w_product + ROUND_BIAS) >>> (gain_width - 1);
  assign w_satOut    = data_width'(saturate(64'(w_rounded), data_width));

  // Stage 2: register the scaled sample, holding it when nothing is valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out    <= '0;
      r_valid2 <= 1'b0;
    end else begin
      r_valid2 <= r_valid1;
      if (r_valid1) begin
        r_out <= w_satOut;
      end
    end
  end

  assign o_sample = r_out;
  assign o_valid  = r_valid2;

endmodule

// File: rtl/safety_mute_ramp.sv
// Safety mute ramp: fades the audio gain to zero when the upstream health
// monitor reports a fault, holds mute until a run of clean samples has been
// seen, then fades back to unity. Power-up starts as a soft fade-in.
// Optional build macro SAFETY_MUTE_AUTO_RECOVER_EN: leave MUTED on its own
// once the hold expires with a clean, healthy sample (clear is then unused).
module safety_mute_ramp
  import safety_mute_ramp_pkg::*;
#(
  parameter int data_width = 16,
  parameter int gain_width = 16,
  parameter int ramp_log2  = 4,
  parameter int mute_hold  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic signed [data_width-1:0] sample_in,
  input  logic                         health,
  input  logic                         peak_detect,
  input  logic                         envl_detect,
  input  logic                         clear,
  output logic signed [data_width-1:0] sample_out,
  output logic                         sample_out_valid,
  output logic                         muted
);

  localparam logic [gain_width-1:0] UNITY     = gain_width'(unityGain(gain_width));
  localparam logic [gain_width-1:0] STEP      = UNITY >> ramp_log2;
  localparam int                    HW        = $clog2(mute_hold + 1);
  localparam logic [HW-1:0]         HOLD_LOAD = HW'(mute_hold);

  state_t                r_state;
  logic [gain_width-1:0] r_gain;
  logic [HW-1:0]         r_holdCtr;
  logic                  r_muted;

  state_t                w_nextState;
  logic [gain_width-1:0] w_nextGain;
  logic [HW-1:0]         w_nextHold;
  logic                  w_accept;
  logic                  w_fault;
  logic [gain_width:0]   w_gainSum;
  logic [HW-1:0]         w_holdDec;

  assign w_accept  = sample_valid & enable;
  assign w_fault   = ~health | peak_detect | envl_detect;
  assign w_gainSum = {1'b0, r_gain} + {1'b0, STEP};
  assign w_holdDec = (r_holdCtr != '0) ? (r_holdCtr - HW'(1)) : '0;

  // Next state, gain and hold count; everything advances per accepted
  // sample except the un-mute request, which is checked every enabled cycle
  always_comb begin
    w_nextState = r_state;
    w_nextGain  = r_gain;
    w_nextHold  = r_holdCtr;
    case (r_state)
      PASS: begin
        w_nextGain = UNITY;
        if (w_accept && w_fault) begin
          w_nextState = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (w_accept) begin
          if (r_gain <= STEP) begin
            w_nextGain  = '0;
            w_nextState = MUTED;
            w_nextHold  = HOLD_LOAD;
          end else begin
            w_nextGain = r_gain - STEP;
          end
        end
      end
      MUTED: begin
        w_nextGain = '0;
`ifdef SAFETY_MUTE_AUTO_RECOVER_EN
        if (w_accept) begin
          if (w_fault) begin
            w_nextHold = HOLD_LOAD;
          end else if ((r_holdCtr == '0) && health) begin
            w_nextState = FADE_IN;
          end else begin
            w_nextHold = w_holdDec;
          end
        end
`else
        if (enable && clear && (r_holdCtr == '0) && health) begin
          w_nextState = FADE_IN;
        end else if (w_accept) begin
          w_nextHold = w_fault ? HOLD_LOAD : w_holdDec;
        end
`endif
      end
      FADE_IN: begin
        if (w_accept) begin
          if (w_fault) begin
            w_nextState = FADE_OUT;
          end else if (w_gainSum >= {1'b0, UNITY}) begin
            w_nextGain  = UNITY;
            w_nextState = PASS;
          end else begin
            w_nextGain = w_gainSum[gain_width-1:0];
          end
        end
      end
      default: begin
        w_nextState = FADE_IN;
        w_nextGain  = '0;
      end
    endcase
  end

  // Gain controller registers; reset lands in a soft-start fade-in from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FADE_IN;
      r_gain    <= '0;
      r_holdCtr <= '0;
      r_muted   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_gain    <= w_nextGain;
      r_holdCtr <= w_nextHold;
      r_muted   <= (w_nextState == MUTED);
    end
  end

  assign muted = r_muted;

  safety_gain_scaler #(
    .data_width (data_width),
    .gain_width (gain_width)
  ) u_scaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (sample_valid),
    .i_sample (sample_in),
    .i_gain   (r_gain),
    .o_sample (sample_out),
    .o_valid  (sample_out_valid)
  );

endmodule

// File: tb/tb_safety_mute_ramp.sv
// Bench for safety_mute_ramp: directed sample sequences with literal
// expectations at key points, plus a sample-level reference model of the
// gain ramp that is compared against the outputs every cycle.
module tb_safety_mute_ramp;

  localparam int UNITY = 32768;
  localparam int STEP  = 2048;
  localparam int HOLD  = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  logic               health;
  logic               peak_detect;
  logic               envl_detect;
  logic               clear;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic               muted;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  safety_mute_ramp #(
    .data_width (16),
    .gain_width (16),
    .ramp_log2  (4),
    .mute_hold  (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .health           (health),
    .peak_detect      (peak_detect),
    .envl_detect      (envl_detect),
    .clear            (clear),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .muted            (muted)
  );

  // Reference model: gain as an integer, direction of travel (+1 fading up,
  // -1 fading down, 0 resting at unity or at zero), and the clean-sample hold
  int mGain    = 0;
  int mDir     = 1;
  int mHold    = 0;
  bit p1Valid  = 1'b0;
  int p1Data   = 0;
  bit expValid = 1'b0;
  int expData  = 0;

  function automatic int scaleRef(input int s, input int g);
    longint p;
    p = longint'(s) * longint'(g);
    p = (p + 64'sd16384) >>> 15;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  function automatic int modelMuted();
    return ((mDir == 0) && (mGain == 0)) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin : modelBlk
    bit accept;
    bit fault;
    if (!reset_n) begin
      mGain = 0; mDir = 1; mHold = 0;
      p1Valid = 1'b0; p1Data = 0; expValid = 1'b0; expData = 0;
    end else begin
      expValid = p1Valid;
      if (p1Valid) expData = p1Data;
      p1Valid = sample_valid;
      if (sample_valid) p1Data = scaleRef(int'(sample_in), mGain);
      accept = sample_valid & enable;
      fault  = !health || peak_detect || envl_detect;
      if (modelMuted() == 1) begin
        if (enable && clear && mHold == 0 && health) begin
          mDir = 1;
        end else if (accept) begin
          mHold = fault ? HOLD : ((mHold > 0) ? mHold - 1 : 0);
        end
      end else if (accept) begin
        if (mDir == 0) begin
          if (fault) mDir = -1;
        end else if (mDir < 0) begin
          if (mGain <= STEP) begin
            mGain = 0; mDir = 0; mHold = HOLD;
          end else begin
            mGain = mGain - STEP;
          end
        end else begin
          if (fault) mDir = -1;
          else if (mGain + STEP >= UNITY) begin
            mGain = UNITY; mDir = 0;
          end else begin
            mGain = mGain + STEP;
          end
        end
      end
    end
  end

  task automatic checkValue(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checkValue("model valid", int'(sample_out_valid), int'(expValid));
      checkValue("model data", int'(sample_out), expData);
      checkValue("model muted", int'(muted), modelMuted());
    end
  end

  // Drive one sample for one cycle (called at a negedge, returns at the next)
  task automatic applyStimulus(input int s, input bit pk, input bit env, input bit hl);
    sample_in    = 16'(s);
    sample_valid = 1'b1;
    peak_detect  = pk;
    envl_detect  = env;
    health       = hl;
    @(negedge clk);
    sample_valid = 1'b0;
    peak_detect  = 1'b0;
    envl_detect  = 1'b0;
    health       = 1'b1;
    checkValue("valid one cycle early", int'(sample_out_valid), 0);
  endtask

  // Wait for the sample's second-cycle output and check it
  task automatic checkOutput(input string name, input int expected);
    @(negedge clk);
    checkValue({name, " valid"}, int'(sample_out_valid), 1);
    checkValue(name, int'(sample_out), expected);
  endtask

  task automatic sampleClean(input int s);
    applyStimulus(s, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; sample_valid = 1'b0; sample_in = '0;
    health = 1'b1; peak_detect = 1'b0; envl_detect = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("reset sample_out", int'(sample_out), 0);
    checkValue("reset valid", int'(sample_out_valid), 0);
    checkValue("reset muted", int'(muted), 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] soft-start ramp");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1000, 1'b0, 1'b0, 1'b1);
      case (i)
        0:       checkOutput("t1 first", 0);
        1:       checkOutput("t1 second", 63);
        2:       checkOutput("t1 third", 125);
        15:      checkOutput("t1 last ramp", 938);
        default: if (i >= 16) checkOutput("t1 unity", 1000); else @(negedge clk);
      endcase
    end
    checkValue("t1 muted", int'(muted), 0);

    $display("[TB] full-scale pass-through and fade-out");
    applyStimulus(-32768, 1'b0, 1'b0, 1'b1);
    checkOutput("t2 min", -32768);
    applyStimulus(32767, 1'b0, 1'b0, 1'b1);
    checkOutput("t2 max", 32767);
    applyStimulus(1000, 1'b1, 1'b0, 1'b1);
    checkOutput("t2 fault sample", 1000);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1000, 1'b0, 1'b0, 1'b1);
      if (k == 14) checkValue("t2 muted early", int'(muted), 0);
      if (k == 15) checkValue("t2 muted", int'(muted), 1);
      case (k)
        0:       checkOutput("t2 fade start", 1000);
        8:       checkOutput("t2 fade half", 500);
        15:      checkOutput("t2 fade end", 63);
        default: @(negedge clk);
      endcase
    end

    $display("[TB] clear handling");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1000, 1'b0, 1'b0, 1'b1);
      if (k == 0) checkOutput("t3 muted out", 0); else @(negedge clk);
    end
    pulseClear();
    checkValue("t3 early clear ignored", int'(muted), 1);
    for (int k = 0; k < 3; k++) sampleClean(1000);
    pulseClear();
    checkValue("t3 clear honoured", int'(muted), 0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1000, 1'b0, 1'b0, 1'b1);
      case (k)
        0:       checkOutput("t3 ramp first", 0);
        1:       checkOutput("t3 ramp second", 63);
        16:      checkOutput("t3 ramp unity", 1000);
        default: @(negedge clk);
      endcase
    end

    $display("[TB] fault during fade-in and hold reload");
    applyStimulus(1000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 16; k++) sampleClean(1000);
    checkValue("t4 muted after health fault", int'(muted), 1);
    for (int k = 0; k < 8; k++) sampleClean(1000);
    pulseClear();
    checkValue("t4 unmuted", int'(muted), 0);
    for (int k = 0; k < 8; k++) sampleClean(1000);
    applyStimulus(1000, 1'b0, 1'b1, 1'b1);
    checkOutput("t4 envl sample", 500);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1000, 1'b0, 1'b0, 1'b1);
      if (k == 6) checkValue("t4 muted early", int'(muted), 0);
      if (k == 7) checkValue("t4 muted", int'(muted), 1);
      if (k == 0) checkOutput("t4 fade from half", 500); else @(negedge clk);
    end
    for (int k = 0; k < 3; k++) sampleClean(1000);
    applyStimulus(1000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 7; k++) sampleClean(1000);
    pulseClear();
    checkValue("t4 hold reloaded", int'(muted), 1);
    sampleClean(1000);
    pulseClear();
    checkValue("t4 clear after hold", int'(muted), 0);

    $display("[TB] enable freeze");
    for (int k = 0; k < 4; k++) sampleClean(1000);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1000, 1'b0, 1'b0, 1'b1);
      checkOutput("t5 frozen", 250);
    end
    enable = 1'b1;
    applyStimulus(1000, 1'b0, 1'b0, 1'b1);
    checkOutput("t5 resume", 250);
    applyStimulus(1000, 1'b0, 1'b0, 1'b1);
    checkOutput("t5 next step", 313);

    $display("[TB] back-to-back samples and async reset");
    for (int k = 0; k < 12; k++) sampleClean(1000);
    sample_valid = 1'b1;
    sample_in    = 16'sd100;
    @(negedge clk);
    sample_in = 16'sd200;
    @(negedge clk);
    sample_in = 16'sd300;
    checkValue("t6 burst 0", int'(sample_out), 100);
    @(negedge clk);
    sample_valid = 1'b0;
    checkValue("t6 burst 1", int'(sample_out), 200);
    @(negedge clk);
    checkValue("t6 burst 2", int'(sample_out), 300);
    applyStimulus(1000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) sampleClean(1000);
    sample_valid = 1'b1;
    sample_in    = 16'sd1000;
    @(negedge clk);
    @(negedge clk);
    checkValue("t6 pre-reset valid", int'(sample_out_valid), 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkValue("t6 reset sample_out", int'(sample_out), 0);
    checkValue("t6 reset valid", int'(sample_out_valid), 0);
    checkValue("t6 reset muted", int'(muted), 0);
    sample_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1000, 1'b0, 1'b0, 1'b1);
    checkOutput("t6 soft start first", 0);
    applyStimulus(1000, 1'b0, 1'b0, 1'b1);
    checkOutput("t6 soft start second", 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
